// File: rtl/sbox_link_buffer_if.sv
// Link handshake bundle: one data word with a valid/ready pair.
// A word moves on a rising clock edge when valid and ready are both high.
// valid and data come from the sender. ready comes from the receiver.
interface sbox_link_buffer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    // The sender drives data/valid and observes ready.
    modport master (output data, output valid, input ready);
    // The receiver observes data/valid and drives ready.
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sbox_link_buffer.sv
// Elastic buffer between two switch boxes. A small circular FIFO decouples
// the upstream and downstream handshakes. Occupancy, a high-water mark and a
// saturating stall counter are exported so the link can be characterised.
module sbox_link_buffer #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,      // asynchronous, active-low
    sbox_link_buffer_if.slave    up,         // from upstream switch-box output
    sbox_link_buffer_if.master   dn,         // to downstream switch-box input
    output logic [CW-1:0]        count,
    output logic [CW-1:0]        hwm,
    input  logic                 clear_hwm,
    output logic [15:0]          stall_cnt
);
    // Handshake rules on both sides:
    // - A push happens when up.valid and up.ready are both high on the edge.
    // - A pop happens when dn.valid and dn.ready are both high on the edge.
    // - up.ready and dn.valid depend only on registered occupancy.
    // - A full FIFO refuses a push even when a pop happens in the same cycle.
    // - An empty FIFO has no bypass, so a pushed word shows up one cycle later.

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    hwm_q, hwm_d;
    logic [15:0]      stall_q, stall_d;
    logic             in_ready;
    logic             out_valid;
    logic             push;
    logic             pop;

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = up.valid && in_ready;
    assign pop       = out_valid && dn.ready;

    assign up.ready  = in_ready;
    assign dn.valid  = out_valid;
    assign dn.data   = mem_q[rd_ptr_q];

    assign count     = count_q;
    assign hwm       = hwm_q;
    assign stall_cnt = stall_q;

    // Next-state for pointers, occupancy, high-water mark and stall counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        hwm_d    = hwm_q;
        stall_d  = stall_q;

        // DEPTH is a power of two, so the pointers wrap naturally.
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        // A clear reloads from the post-update occupancy and wins over tracking.
        if (clear_hwm) begin
            hwm_d = count_d;
        end else if (count_d > hwm_q) begin
            hwm_d = count_d;
        end

        if (up.valid && !in_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Control state register. Reset discards any words in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hwm_q    <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hwm_q    <= hwm_d;
            stall_q  <= stall_d;
        end
    end

    // Storage has no reset. Only an accepted word is written, so a garbage
    // value on up.data never reaches the array.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= up.data;
        end
    end
endmodule
